// File: rtl/data_mem_responder.sv
// Memory responder for a multicycle control FSM: busy/done handshake in front of a word-addressed RAM.
// Optional misaligned-address rejection is enabled by defining MISALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } state_t;

`ifdef MISALIGN_CHECK_EN
    localparam bit MisalignEn = 1'b1;
`else
    localparam bit MisalignEn = 1'b0;
`endif

    localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

    state_t              state;
    logic [3:0]          cnt;
    logic                write_q;
    logic                err_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                range_bad;
    logic                misalign;
    logic                access_now;

    assign range_bad  = |addr[31:ADDR_W+2];
    assign misalign   = MisalignEn && (addr[1:0] != 2'b00);
    assign access_now = (state == WAIT) && (cnt == 4'd0);

    // NOTE: the request latches (op, index, data, error) carry no reset; they are
    // only consumed after an accept has loaded them, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (memRead || memWrite) begin
                        write_q <= memWrite && !memRead;
                        err_q   <= (memRead && memWrite) || range_bad || misalign;
                        idx_q   <= addr[ADDR_W+1:2];
                        wdata_q <= wdata;
                        cnt     <= CntLoad;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (!err_q && !write_q) rdata <= mem[idx_q];
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    done  <= 1'b1;
                    err   <= err_q;
                    state <= HOLD;
                end
                HOLD: begin
                    // Requests are levels; wait for both to drop so one request gives one pulse.
                    if (!memRead && !memWrite) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the RAM array is never reset; a reset on the commit edge only suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && access_now && write_q && !err_q) mem[idx_q] <= wdata_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (busy/done handshake, errors, reset abort).
// Honours MISALIGN_CHECK_EN for the misaligned-address case.
module tb_data_mem_responder;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 2;

    logic              clk;
    logic              rst;
    logic              memRead;
    logic              memWrite;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;

    int tests_run = 0;
    int tests_failed = 0;

    data_mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .memRead (memRead),
        .memWrite(memWrite),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, return edges from accept to done, then release and let HOLD exit.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic e,
                          output logic [31:0] rd_o);
        @(negedge clk);
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = d;
        lat      = -1;
        e        = 1'bx;
        rd_o     = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat  = i - 1;
                e    = err;
                rd_o = rdata;
                break;
            end
        end
        memRead  = 1'b0;
        memWrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    int          lat;
    logic        e;
    logic [31:0] rv;
    int          pulses;

    initial begin
        rst      = 1'b1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        addr     = '0;
        wdata    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rdata", rdata, 32'h0);
        rst = 1'b0;

        // Basic write then read back.
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, rv);
        check("wr_latency", 32'(lat), 32'(LATENCY + 1));
        check("wr_err", 32'(e), 32'd0);
        check("wr_released_busy", 32'(busy), 32'd0);
        check("wr_done_dropped", 32'(done), 32'd0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, lat, e, rv);
        check("rd_latency", 32'(lat), 32'(LATENCY + 1));
        check("rd_data", rv, 32'hDEADBEEF);
        check("rd_err", 32'(e), 32'd0);

        // Held read level: one pulse, busy until the level drops.
        @(negedge clk);
        memRead = 1'b1;
        addr    = 32'h10;
        pulses  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_busy", 32'(busy), 32'd1);
        memRead = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("held_release_busy", 32'(busy), 32'd0);

        // Illegal op must not touch the RAM.
        do_req(1'b1, 1'b1, 32'h10, 32'h11111111, lat, e, rv);
        check("both_err", 32'(e), 32'd1);
        check("both_rdata_kept", rv, 32'hDEADBEEF);
        check("err_cleared", 32'(err), 32'd0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, lat, e, rv);
        check("both_ram_unchanged", rv, 32'hDEADBEEF);

        // Highest in-range word, then first out-of-range address.
        do_req(1'b0, 1'b1, 32'hFFC, 32'h12345678, lat, e, rv);
        check("top_wr_err", 32'(e), 32'd0);
        do_req(1'b1, 1'b0, 32'hFFC, 32'h0, lat, e, rv);
        check("top_rd_data", rv, 32'h12345678);
        do_req(1'b1, 1'b0, 32'h1000, 32'h0, lat, e, rv);
        check("range_err", 32'(e), 32'd1);
        check("range_rdata_kept", rv, 32'h12345678);
        do_req(1'b0, 1'b1, 32'h1010, 32'hBAD0BAD0, lat, e, rv);
        check("range_wr_err", 32'(e), 32'd1);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, lat, e, rv);
        check("range_no_alias_write", rv, 32'hDEADBEEF);

        // Misaligned address: word 4 without the check, error with it.
        do_req(1'b1, 1'b0, 32'h13, 32'h0, lat, e, rv);
`ifdef MISALIGN_CHECK_EN
        check("misalign_err", 32'(e), 32'd1);
`else
        check("misalign_err", 32'(e), 32'd0);
        check("misalign_data", rv, 32'hDEADBEEF);
`endif

        // Reset on the first WAIT edge aborts the pending write.
        do_req(1'b0, 1'b1, 32'h20, 32'h0000A5A5, lat, e, rv);
        @(negedge clk);
        memWrite = 1'b1;
        addr     = 32'h20;
        wdata    = 32'h5;
        @(posedge clk);
        @(negedge clk);
        check("abort_accepted_busy", 32'(busy), 32'd1);
        rst      = 1'b1;
        memWrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdata", rdata, 32'h0);
        repeat (LATENCY + 3) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, lat, e, rv);
        check("abort_ram_prior", rv, 32'h0000A5A5);
        check("abort_rd_latency", 32'(lat), 32'(LATENCY + 1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
